// File: rtl/alu_seq.sv
// Registered ALU with a START/BUSY/READY handshake. FWD/ADD/AND/OR finish in one cycle.
// MUL (unsigned shift-add) and SLL/SRA/ROR (one bit per cycle) are iterative.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             READY,
  output logic             BUSY,
  output logic             ZERO,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_OPND   = WIDTH'(WIDTH);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           op, op_nxt;
  logic [2*WIDTH-1:0]   prod, prod_nxt, mcand, mcand_nxt, prod_step;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [WIDTH-1:0]     shreg, shreg_nxt, sh_step;
  logic [WIDTH-1:0]     result, result_nxt, sum;
  logic [CW-1:0]        shamt;
  logic                 ready_nxt, ovf, ovf_nxt, zero;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [2:0] sel, input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    case (sel)
      OP_SLL:  return v << 1;
      OP_SRA:  return unsigned'(sv >>> 1);
      OP_ROR:  return {v[0], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op;
    prod_nxt   = prod;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    shreg_nxt  = shreg;
    result_nxt = result;
    ovf_nxt    = ovf;
    ready_nxt  = 1'b0;
    sum        = DATA1 + DATA2;
    shamt      = (DATA2 < W_OPND) ? DATA2[CW-1:0] : CNT_FULL;
    prod_step  = mplier[0] ? prod + mcand : prod;
    sh_step    = shift_one(op, shreg);

    case (state)
      S_IDLE: begin
        if (START) begin
          op_nxt = SELECT;
          case (SELECT)
            OP_FWD: begin result_nxt = DATA2;         ovf_nxt = 1'b0; ready_nxt = 1'b1; end
            OP_ADD: begin result_nxt = sum; ovf_nxt = add_ovf(DATA1, DATA2, sum); ready_nxt = 1'b1; end
            OP_AND: begin result_nxt = DATA1 & DATA2; ovf_nxt = 1'b0; ready_nxt = 1'b1; end
            OP_OR:  begin result_nxt = DATA1 | DATA2; ovf_nxt = 1'b0; ready_nxt = 1'b1; end
            OP_MUL: begin
              state_nxt  = S_MUL;
              cnt_nxt    = CNT_FULL;
              prod_nxt   = '0;
              mcand_nxt  = {{WIDTH{1'b0}}, DATA1};
              mplier_nxt = DATA2;
            end
            default: begin
              // A zero shift amount completes immediately, like a single-cycle op.
              if (shamt == '0) begin
                result_nxt = DATA1;
                ovf_nxt    = 1'b0;
                ready_nxt  = 1'b1;
              end else begin
                state_nxt = S_SHIFT;
                cnt_nxt   = shamt;
                shreg_nxt = DATA1;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        prod_nxt   = prod_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_nxt = prod_step[WIDTH-1:0];
          ovf_nxt    = |prod_step[2*WIDTH-1:WIDTH];
          ready_nxt  = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_SHIFT: begin
        shreg_nxt = sh_step;
        cnt_nxt   = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_nxt = sh_step;
          ovf_nxt    = 1'b0;
          ready_nxt  = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
      READY  <= 1'b0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      READY  <= ready_nxt;
      zero   <= (result_nxt == '0);
      ovf    <= ovf_nxt;
    end
  end

  // Working operands are only meaningful while an op is in flight, so they carry no reset.
  always_ff @(posedge CLK) begin
    op     <= op_nxt;
    prod   <= prod_nxt;
    mcand  <= mcand_nxt;
    mplier <= mplier_nxt;
    shreg  <= shreg_nxt;
  end

  assign RESULT = result;
  assign ZERO   = zero;
  assign OVF    = ovf;
  assign BUSY   = (state != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with hand-computed expected results.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RESET, START, READY, BUSY, ZERO, OVF;
  logic [7:0] DATA1, DATA2, RESULT;
  logic [2:0] SELECT;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] FWD = 3'd0, ADD = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         MUL = 3'd4, SLL = 3'd5, SRA = 3'd6, ROR = 3'd7;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .START(START), .RESULT(RESULT), .READY(READY), .BUSY(BUSY), .ZERO(ZERO), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!READY && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, nrdy, rdy_at;
    logic [7:0] rres;
    RESET = 1'b1; START = 1'b0; SELECT = FWD; DATA1 = '0; DATA2 = '0;
    tick(); tick();
    RESET = 1'b0;
    check("rst_result", RESULT, 8'h00);
    check("rst_ready", READY, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_zero", ZERO, 1'b1);
    check("rst_ovf", OVF, 1'b0);

    do_op(ADD, 8'h05, 8'h21);
    check("add1_res", RESULT, 8'h26); check("add1_rdy", READY, 1'b1);
    check("add1_zero", ZERO, 1'b0);   check("add1_ovf", OVF, 1'b0);
    tick();
    check("add1_rdy_pulse", READY, 1'b0);
    do_op(ADD, 8'h7F, 8'h01);
    check("add2_res", RESULT, 8'h80); check("add2_ovf", OVF, 1'b1); check("add2_zero", ZERO, 1'b0);
    do_op(ADD, 8'hFF, 8'h01);
    check("add3_res", RESULT, 8'h00); check("add3_zero", ZERO, 1'b1); check("add3_ovf", OVF, 1'b0);

    do_op(FWD, 8'hA5, 8'h21);  check("fwd_res", RESULT, 8'h21); check("fwd_rdy", READY, 1'b1);
    do_op(AND_, 8'hA5, 8'h21); check("and_res", RESULT, 8'h21);
    do_op(OR_, 8'hA5, 8'h21);  check("or_res", RESULT, 8'hA5);
    do_op(AND_, 8'h55, 8'hAA); check("and0_res", RESULT, 8'h00); check("and0_zero", ZERO, 1'b1);

    tick();
    DATA1 = 8'hA5; DATA2 = 8'h21; START = 1'b1; SELECT = FWD;
    tick(); check("b2b_fwd_rdy", READY, 1'b1); check("b2b_fwd", RESULT, 8'h21);
    SELECT = ADD;
    tick(); check("b2b_add_rdy", READY, 1'b1); check("b2b_add", RESULT, 8'hC6);
    SELECT = AND_;
    tick(); check("b2b_and_rdy", READY, 1'b1); check("b2b_and", RESULT, 8'h21);
    SELECT = OR_;
    tick(); check("b2b_or_rdy", READY, 1'b1); check("b2b_or", RESULT, 8'hA5);
    START = 1'b0;
    tick(); check("b2b_end_rdy", READY, 1'b0);

    do_op(MUL, 8'h15, 8'h05);
    check("mul1_busy", BUSY, 1'b1); check("mul1_rdy_early", READY, 1'b0);
    wait_ready(cyc);
    check("mul1_lat", cyc, 8); check("mul1_res", RESULT, 8'h69);
    check("mul1_ovf", OVF, 1'b0); check("mul1_busy_done", BUSY, 1'b0);
    do_op(MUL, 8'h10, 8'h10);
    wait_ready(cyc);
    check("mul2_lat", cyc, 8); check("mul2_res", RESULT, 8'h00);
    check("mul2_ovf", OVF, 1'b1); check("mul2_zero", ZERO, 1'b1);

    do_op(SRA, 8'hA5, 8'd3);
    check("sra_busy", BUSY, 1'b1);
    wait_ready(cyc); check("sra_lat", cyc, 3); check("sra_res", RESULT, 8'hF4);
    do_op(ROR, 8'h73, 8'd4);
    wait_ready(cyc); check("ror_lat", cyc, 4); check("ror_res", RESULT, 8'h37);
    do_op(ROR, 8'h73, 8'd8);
    wait_ready(cyc); check("ror8_lat", cyc, 8); check("ror8_res", RESULT, 8'h73);
    do_op(SLL, 8'h01, 8'd0);
    check("sll0_rdy", READY, 1'b1); check("sll0_busy", BUSY, 1'b0); check("sll0_res", RESULT, 8'h01);
    do_op(SLL, 8'h01, 8'd200);
    wait_ready(cyc); check("sllbig_lat", cyc, 8); check("sllbig_res", RESULT, 8'h00);
    check("sllbig_zero", ZERO, 1'b1);

    do_op(MUL, 8'h03, 8'h03);
    nrdy = 0; rdy_at = 0; rres = '0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) begin SELECT = ADD; DATA1 = 8'h05; DATA2 = 8'h21; START = 1'b1; end
      if (i == 3) START = 1'b0;
      tick();
      if (READY) begin nrdy++; rdy_at = i; rres = RESULT; end
    end
    check("busy_start_nrdy", nrdy, 1); check("busy_start_at", rdy_at, 8);
    check("busy_start_res", rres, 8'h09);
    do_op(MUL, 8'h03, 8'h03);
    wait_ready(cyc); check("mul3_res", RESULT, 8'h09);
    do_op(ADD, 8'h05, 8'h21);
    check("rdy_cycle_add_rdy", READY, 1'b1); check("rdy_cycle_add_res", RESULT, 8'h26);

    do_op(MUL, 8'h15, 8'h05);
    tick(); tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_res", RESULT, 8'h00); check("abort_busy", BUSY, 1'b0);
    check("abort_rdy", READY, 1'b0);   check("abort_zero", ZERO, 1'b1);
    check("abort_ovf", OVF, 1'b0);
    nrdy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (READY) nrdy++;
    end
    check("abort_no_rdy", nrdy, 0);
    do_op(ADD, 8'h05, 8'h21);
    check("post_abort_rdy", READY, 1'b1); check("post_abort_res", RESULT, 8'h26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ALU used by the CPU datapath. It adds multiply and shift operations, status flags, and a START/BUSY/READY handshake. FORWARD, ADD, AND and OR complete in 1 cycle. MUL and the shifts run iteratively over several cycles. The block sits between the register file read ports and the writeback mux. The control unit stalls while BUSY=1.

Parameters:
WIDTH, 8, operand/result width in bits (WIDTH >= 2); counter width is derived as clog2(WIDTH+1).

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
DATA1  input  WIDTH  operand 1; the shifted/multiplicand operand.
DATA2  input  WIDTH  operand 2; multiplier, or unsigned shift amount.
SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRA, 111 ROR.
START  input  1  request; sampled only in IDLE.
RESULT  output  WIDTH  registered result; held until the next completion.
READY  output  1  one-cycle pulse; RESULT/ZERO/OVF updated this cycle.
BUSY  output  1  high while a multi-cycle op is in progress.
ZERO  output  1  registered (RESULT == 0).
OVF  output  1  registered overflow flag.

Behaviour:
- Reset, when RESET=1 at a posedge:
  - RESULT=0, READY=0, BUSY=0, ZERO=1, OVF=0, state=IDLE.
  - Reset has priority over everything, including an operation in progress, which is aborted with no READY.
- States: IDLE, MUL, SHIFT.
- IDLE, START=1 at edge k: DATA1, DATA2 and SELECT are latched internally. Inputs may change afterwards.
- Single-cycle ops (FWD/ADD/AND/OR):
  - At edge k, RESULT is updated and READY=1 for the following cycle. State stays IDLE, so a START every cycle gives one result per cycle.
  - FWD = DATA2.
  - ADD = (DATA1+DATA2) mod 2^WIDTH. OVF = signed overflow (operands same sign, result sign differs).
  - AND, OR are bitwise.
  - OVF=0 for FWD/AND/OR.
- MUL:
  - Edge k → state MUL, BUSY=1, counter=WIDTH.
  - Each edge performs one unsigned shift-add step and decrements the counter.
  - At edge k+WIDTH: RESULT = low WIDTH bits of the product, OVF = (upper WIDTH bits != 0), READY=1, BUSY=0, state IDLE.
- Shifts (SLL/SRA/ROR):
  - n = DATA2 (unsigned) if DATA2 < WIDTH, else WIDTH.
  - n=0: completes at edge k like a single-cycle op, with RESULT=DATA1.
  - n>0: edge k → SHIFT, BUSY=1. Each edge shifts one bit. Completion and READY at edge k+n.
  - SLL shifts in zeros; n=WIDTH gives 0.
  - SRA replicates the MSB; n=WIDTH gives all sign bits.
  - ROR rotates right; n=WIDTH gives DATA1.
  - OVF=0.
- ZERO is updated together with RESULT on every completion.
- READY is high for exactly one cycle per accepted START. It is never asserted on reset or abort.
- START while BUSY=1 is ignored: no latch, no queueing.
- START in the cycle where READY=1 is accepted, since state is already IDLE.
- Opcode X/Z handling is out of scope. All 8 codes are defined.

Test Plan:
1. Reset, then ADD with DATA1=0x05, DATA2=0x21 → edge after START: RESULT=0x26, READY pulse of 1 cycle, ZERO=0, OVF=0. ADD 0x7F+0x01 → RESULT=0x80, OVF=1. ADD 0xFF+0x01 → RESULT=0x00, ZERO=1, OVF=0.
2. DATA1=0xA5, DATA2=0x21 → FWD=0x21, AND=0x21, OR=0xA5, each with 1-cycle latency. AND 0x55&0xAA → 0x00, ZERO=1. Holding START high across 4 ops gives 4 consecutive READY pulses.
3. MUL 0x15×0x05 → BUSY=1 for 8 cycles, RESULT=0x69 with READY at edge k+8, OVF=0. MUL 0x10×0x10 → RESULT=0x00, OVF=1, ZERO=1.
4. SRA 0xA5 by 3 → RESULT=0xF4 at k+3. ROR 0x73 by 4 → 0x37 at k+4. SLL 0x01 by 0 → 0x01 at k (no BUSY). SLL 0x01 by 200 → 0x00 at k+8.
5. START MUL 0x03×0x03, then pulse START with ADD at cycle 2 → ADD ignored, single READY with RESULT=0x09. Next START ADD accepted in the READY cycle → 0x05+0x21 gives 0x26 on the following edge.
6. RESET asserted at cycle 4 of MUL 0x15×0x05 → next edge: RESULT=0, BUSY=0, READY=0, ZERO=1, OVF=0. No READY follows. A new ADD after release works normally.
